// File: rtl/alu_multiciclo_pkg.sv
// ALU_ctrl op codes, FSM states and shift-direction encoding
// shared by the multicycle ALU and its iterative shifter.
package alu_multiciclo_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_ADDU = 4'd8;
  localparam logic [3:0] ALU_SUBU = 4'd9;
  localparam logic [3:0] ALU_SLL  = 4'd10;
  localparam logic [3:0] ALU_SRL  = 4'd11;
  localparam logic [3:0] ALU_SRA  = 4'd12;
  localparam logic [3:0] ALU_SLLV = 4'd13;
  localparam logic [3:0] ALU_SRLV = 4'd14;
  localparam logic [3:0] ALU_SRAV = 4'd15;

  typedef enum logic {
    ALUM_IDLE,
    ALUM_SHIFT
  } alum_state_e;

  typedef enum logic [1:0] {
    SH_LEFT,
    SH_RIGHT_L,
    SH_RIGHT_A
  } shift_dir_e;

endpackage

// File: rtl/alu_multiciclo_shift_iter.sv
// Iterative shifter: one bit per step, counting down the
// remaining shift amount; last flags the final step.
module alu_shift_iter
  import alu_multiciclo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] din,
  input  logic [SHW-1:0]   k,
  input  shift_dir_e       shift_dir,
  output logic [WIDTH-1:0] acc_next,
  output logic             last
);

  logic [WIDTH-1:0] acc;
  logic [SHW-1:0]   cnt;
  shift_dir_e       dir;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
      cnt <= '0;
      dir <= SH_LEFT;
    end else if (load) begin
      acc <= din;
      cnt <= k;
      dir <= shift_dir;
    end else if (step) begin
      acc <= acc_next;
      cnt <= cnt - SHW'(1);
    end
  end

  always_comb begin
    acc_next = {acc[WIDTH-2:0], 1'b0};
    case (dir)
      SH_RIGHT_L: acc_next = {1'b0, acc[WIDTH-1:1]};
      SH_RIGHT_A: acc_next = {acc[WIDTH-1], acc[WIDTH-1:1]};
      default:    acc_next = {acc[WIDTH-2:0], 1'b0};
    endcase
  end

  assign last = (cnt == SHW'(1));

endmodule

// File: rtl/alu_multiciclo.sv
// EX-stage ALU: registered single-cycle arith/logic ops and
// bit-serial shifts behind a start/busy/done handshake.
module alu_multiciclo
  import alu_multiciclo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       ALU_ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [SHW-1:0]   shamt,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  alum_state_e      state;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ov;
  logic             is_shift;
  logic [SHW-1:0]   k;
  shift_dir_e       dir;
  logic             load;
  logic             last;
  logic [WIDTH-1:0] acc_next;

  assign sum  = op_a + op_b;
  assign diff = op_a - op_b;

  always_comb begin
    alu_res  = '0;
    alu_ov   = 1'b0;
    is_shift = 1'b0;
    k        = shamt;
    dir      = SH_LEFT;
    case (ALU_ctrl)
      ALU_ADD: begin
        alu_res = sum;
        alu_ov  = (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                  (sum[WIDTH-1] != op_a[WIDTH-1]);
      end
      ALU_SUB: begin
        alu_res = diff;
        alu_ov  = (op_a[WIDTH-1] != op_b[WIDTH-1]) &&
                  (diff[WIDTH-1] != op_a[WIDTH-1]);
      end
      ALU_ADDU: alu_res = sum;
      ALU_SUBU: alu_res = diff;
      ALU_AND:  alu_res = op_a & op_b;
      ALU_OR:   alu_res = op_a | op_b;
      ALU_XOR:  alu_res = op_a ^ op_b;
      ALU_NOR:  alu_res = ~(op_a | op_b);
      ALU_SLT:
        alu_res = {{(WIDTH-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      ALU_SLTU:
        alu_res = {{(WIDTH-1){1'b0}}, op_a < op_b};
      ALU_SLL:  is_shift = 1'b1;
      ALU_SRL: begin
        is_shift = 1'b1;
        dir      = SH_RIGHT_L;
      end
      ALU_SRA: begin
        is_shift = 1'b1;
        dir      = SH_RIGHT_A;
      end
      ALU_SLLV: begin
        is_shift = 1'b1;
        k        = op_a[SHW-1:0];
      end
      ALU_SRLV: begin
        is_shift = 1'b1;
        k        = op_a[SHW-1:0];
        dir      = SH_RIGHT_L;
      end
      ALU_SRAV: begin
        is_shift = 1'b1;
        k        = op_a[SHW-1:0];
        dir      = SH_RIGHT_A;
      end
      default: ;
    endcase
    // zero-distance shifts complete like any single-cycle op
    if (is_shift) alu_res = op_b;
  end

  assign load = (state == ALUM_IDLE) && start &&
                is_shift && (k != '0);

  alu_shift_iter #(.WIDTH(WIDTH), .SHW(SHW)) u_shift (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .step      (state == ALUM_SHIFT),
    .din       (op_b),
    .k         (k),
    .shift_dir (dir),
    .acc_next  (acc_next),
    .last      (last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ALUM_IDLE;
      result   <= '0;
      zero     <= 1'b1;
      overflow <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ALUM_IDLE: begin
          if (start) begin
            if (load) begin
              state <= ALUM_SHIFT;
              busy  <= 1'b1;
            end else begin
              result   <= alu_res;
              zero     <= (alu_res == '0);
              overflow <= alu_ov;
              done     <= 1'b1;
            end
          end
        end
        ALUM_SHIFT: begin
          if (last) begin
            state    <= ALUM_IDLE;
            result   <= acc_next;
            zero     <= (acc_next == '0);
            overflow <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
          end
        end
        default: state <= ALUM_IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_multiciclo.md
Name: alu_multiciclo

Overview:
- Execution-stage arithmetic unit that consumes the 4-bit ALU_ctrl operation code produced by the ALU control decoder.
- Single-cycle-registered for arithmetic and logic ops.
- Iterative for all shifts: one bit per clock, which removes the 32-bit barrel shifter from the EX critical path.
- Start/busy/done handshake toward the pipeline hazard/stall logic.

Parameters:
- WIDTH, 32, operand and result width.
- SHW, 5, shift-amount width (log2 WIDTH).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  launch operation; sampled only when idle (busy=0).
- ALU_ctrl  in  4  operation code; values are the shared `definiciones.vh` macros (ADD, SUB, AND, OR, XOR, NOR, SLT, SLTU, ADDU, SUBU, SLL, SRL, SRA, SLLV, SRLV, SRAV).
- op_a  in  WIDTH  rs operand; op_a[SHW-1:0] is the variable shift amount.
- op_b  in  WIDTH  rt/immediate operand; this is the value shifted.
- shamt  in  SHW  instruction shamt field for SLL/SRL/SRA.
- result  out  WIDTH  registered result; held until the next accepted start.
- zero  out  1  registered, (result==0).
- overflow  out  1  registered signed overflow; ADD/SUB only.
- busy  out  1  high while a shift is iterating.
- done  out  1  one-cycle pulse: result/zero/overflow valid.

Behaviour:
- Reset (async, any time including mid-shift): state IDLE; result=0, zero=1, overflow=0, busy=0, done=0, internal counter=0. No done is issued for an aborted op.
- States: IDLE, SHIFT.
- Acceptance: start is accepted in IDLE only. start while busy=1 is ignored, not queued. start in the cycle done=1 is accepted (unit is already IDLE).
- Non-shift op accepted at cycle N:
  - At the edge ending N, result/zero/overflow are loaded.
  - done=1 during N+1. Latency is 1. State stays IDLE.
- Non-shift arithmetic:
  - ADD/SUB: two's complement, wrap modulo 2^WIDTH. overflow = operand signs equal (ADD) or differ (SUB) and result sign differs from op_a sign.
  - ADDU/SUBU: same sum, overflow=0.
  - SLT: signed compare, result = {0..,1} or 0. SLTU: unsigned compare, same encoding.
  - AND/OR/XOR/NOR: bitwise.
  - Undefined code: result=0, overflow=0, done still pulses.
- Shift amount k: shamt for SLL/SRL/SRA; op_a[4:0] for SLLV/SRLV/SRAV.
- Shift with k=0: handled as a non-shift op; result=op_b, done at N+1.
- Shift with k>0 accepted at N:
  - Latch acc=op_b, cnt=k, direction/arith flag. Enter SHIFT; busy=1 during N+1..N+k.
  - Each SHIFT edge: acc shifts 1 bit (left with 0 fill; logical right with 0 fill; arithmetic right replicates bit WIDTH-1); cnt decrements.
  - At the edge where cnt==1: result=final acc, busy←0, done←1, return to IDLE.
  - done=1 in cycle N+k+1. Maximum latency is 32 (k=31).
- Input stability: ALU_ctrl/op_a/op_b/shamt are sampled only at acceptance; changes during SHIFT have no effect.
- zero is updated together with result, never combinationally.
- done never overlaps busy=1.

Decomposition:
- Shared package/header `definiciones.vh` holds the ALU_ctrl code macros (already shared with the decoder) and new state encodings ALUM_IDLE and ALUM_SHIFT.
- One sub-module, alu_shift_iter: acc/cnt datapath with load, step, last outputs.
- The FSM and combinational op logic stay in alu_multiciclo.

Test Plan:
- ADD 0x7FFFFFFF + 0x00000001, start at cycle 5 → done only in cycle 6, result=0x80000000, overflow=1, zero=0. ADDU with the same operands → overflow=0.
- SUB 5−5 → result=0, zero=1, done after 1 cycle. SLT op_a=0xFFFFFFFF, op_b=1 → result=1. SLTU with the same operands → result=0.
- SRA op_b=0x80000000, shamt=4, start at cycle 10 → busy cycles 11–14, done in cycle 15, result=0xF8000000. SRL with the same inputs → result=0x08000000.
- SLLV op_a=0x00000023 (k=3), op_b=0x1 → result=0x8, done 4 cycles after start. Pulse start again at cycle 12 with ADD while busy → ignored, no extra done.
- SLL shamt=0, op_b=0x1234 → result=0x1234, done next cycle, busy never asserted. Back-to-back start in the done cycle is accepted.
- Reset asserted mid-SRL (k=20) at iteration 7 → outputs immediately result=0, zero=1, busy=0, done=0; no done ever issued. A following ADD 2+3 → result=5 after 1 cycle.
